// File: rtl/bitwise_logic_unit_pkg.sv
// Shared encodings for the multi-cycle bitwise logic unit.
// Holds the operation and FSM state enums used by the top and slice.
package blu_pkg;

  typedef enum logic [1:0] {
    OP_AND = 2'b00,
    OP_OR  = 2'b01,
    OP_XOR = 2'b10,
    OP_NOR = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/bitwise_logic_unit_logic_slice.sv
// Combinational SLICE-bit bitwise operator (AND/OR/XOR/NOR).
// Ports: a, b slice operands; op selects function; y slice result.
module logic_slice
  import blu_pkg::*;
#(
  parameter int SLICE = 8
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  op_e              op,
  output logic [SLICE-1:0] y
);

  always_comb begin
    y = '0;
    unique case (op)
      OP_AND: y = a & b;
      OP_OR:  y = a | b;
      OP_XOR: y = a ^ b;
      OP_NOR: y = ~(a | b);
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/bitwise_logic_unit.sv
// Multi-cycle bitwise logic unit: one SLICE-bit slice per cycle.
// Ports: clock/reset, ctrl_start/ctrl_op, data_operandA/B in;
//        data_result, data_isZero, data_resultRDY, busy out.
module bitwise_logic_unit
  import blu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_start,
  input  logic [1:0]       ctrl_op,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_isZero,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NSLICE - 1);

  if ((WIDTH % SLICE) != 0) begin : g_bad_cfg
    $error("WIDTH must be a multiple of SLICE");
  end

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  op_e              op_q, op_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             acc_q, acc_d;
  logic             zero_q, zero_d;

  logic [SLICE-1:0] sl_a;
  logic [SLICE-1:0] sl_b;
  logic [SLICE-1:0] sl_y;

  // One shared slice operator, fed from the current counter position.
  assign sl_a = opa_q[cnt_q*SLICE +: SLICE];
  assign sl_b = opb_q[cnt_q*SLICE +: SLICE];

  logic_slice #(
    .SLICE(SLICE)
  ) u_slice (
    .a (sl_a),
    .b (sl_b),
    .op(op_q),
    .y (sl_y)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    op_d    = op_q;
    res_d   = res_q;
    acc_d   = acc_q;
    zero_d  = zero_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (ctrl_start) begin
          state_d = S_RUN;
          cnt_d   = '0;
          opa_d   = data_operandA;
          opb_d   = data_operandB;
          op_d    = op_e'(ctrl_op);
          res_d   = '0;
          acc_d   = 1'b0;
          zero_d  = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        res_d[cnt_q*SLICE +: SLICE] = sl_y;
        acc_d = acc_q | (|sl_y);
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          // Include the final slice, which is not yet in acc_q.
          state_d = S_DONE;
          cnt_d   = '0;
          zero_d  = ~(acc_q | (|sl_y));
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      op_q    <= OP_AND;
      res_q   <= '0;
      acc_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      op_q    <= op_d;
      res_q   <= res_d;
      acc_q   <= acc_d;
      zero_q  <= zero_d;
    end
  end

  assign data_result    = res_q;
  assign data_isZero    = zero_q;
  assign data_resultRDY = (state_q == S_DONE);
  assign busy           = (state_q == S_RUN);

endmodule

// File: tb/tb_bitwise_logic_unit.sv
// Directed bench for bitwise_logic_unit in three configurations.
// Table vectors plus hand sequences for handshake and reset corners.
module tb_bitwise_logic_unit;

  logic clock;
  logic reset;

  logic        st  [3];
  logic [1:0]  opi [3];
  logic [31:0] ai  [3];
  logic [31:0] bi  [3];

  logic [31:0] res0, res1;
  logic [15:0] res2;
  logic        z0, z1, z2;
  logic        rdy0, rdy1, rdy2;
  logic        bsy0, bsy1, bsy2;

  int n_cmp;
  int n_fail;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  bitwise_logic_unit #(.WIDTH(32), .SLICE(8)) d0 (
    .clock(clock), .reset(reset),
    .ctrl_start(st[0]), .ctrl_op(opi[0]),
    .data_operandA(ai[0]), .data_operandB(bi[0]),
    .data_result(res0), .data_isZero(z0),
    .data_resultRDY(rdy0), .busy(bsy0)
  );

  bitwise_logic_unit #(.WIDTH(32), .SLICE(32)) d1 (
    .clock(clock), .reset(reset),
    .ctrl_start(st[1]), .ctrl_op(opi[1]),
    .data_operandA(ai[1]), .data_operandB(bi[1]),
    .data_result(res1), .data_isZero(z1),
    .data_resultRDY(rdy1), .busy(bsy1)
  );

  bitwise_logic_unit #(.WIDTH(16), .SLICE(4)) d2 (
    .clock(clock), .reset(reset),
    .ctrl_start(st[2]), .ctrl_op(opi[2]),
    .data_operandA(ai[2][15:0]), .data_operandB(bi[2][15:0]),
    .data_result(res2), .data_isZero(z2),
    .data_resultRDY(rdy2), .busy(bsy2)
  );

  function automatic logic [31:0] get_res(input int k);
    case (k)
      0: get_res = res0;
      1: get_res = res1;
      default: get_res = {16'h0, res2};
    endcase
  endfunction

  function automatic logic get_rdy(input int k);
    case (k)
      0: get_rdy = rdy0;
      1: get_rdy = rdy1;
      default: get_rdy = rdy2;
    endcase
  endfunction

  function automatic logic get_z(input int k);
    case (k)
      0: get_z = z0;
      1: get_z = z1;
      default: get_z = z2;
    endcase
  endfunction

  function automatic logic get_bsy(input int k);
    case (k)
      0: get_bsy = bsy0;
      1: get_bsy = bsy1;
      default: get_bsy = bsy2;
    endcase
  endfunction

  function automatic logic [31:0] ref_f(input logic [1:0] op,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    case (op)
      2'b00: ref_f = a & b;
      2'b01: ref_f = a | b;
      2'b10: ref_f = a ^ b;
      default: ref_f = ~(a | b);
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Launch one op on DUT k and wait for its ready pulse (bounded).
  task automatic do_op(input int k, input logic [1:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       output int lat, output int bc,
                       output logic [31:0] r, output logic z,
                       output logic rdy_nx, output logic [31:0] r_nx);
    @(negedge clock);
    st[k] = 1'b1; opi[k] = op; ai[k] = a; bi[k] = b;
    @(posedge clock);
    #1;
    st[k] = 1'b0;
    lat = 0;
    bc = 0;
    while (!get_rdy(k) && lat < 20) begin
      if (get_bsy(k)) bc++;
      @(posedge clock);
      #1;
      lat++;
    end
    r = get_res(k);
    z = get_z(k);
    @(posedge clock);
    #1;
    rdy_nx = get_rdy(k);
    r_nx = get_res(k);
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        z;
  } vec_t;

  vec_t vt [9];

  initial begin
    int lat, bc, cnt;
    logic [31:0] r, r_nx, e;
    logic z, rdy_nx;

    n_cmp = 0;
    n_fail = 0;
    for (int k = 0; k < 3; k++) begin
      st[k] = 1'b0; opi[k] = 2'b00; ai[k] = '0; bi[k] = '0;
    end

    vt[0] = '{2'b00, 32'hF0F0_1234, 32'hFF00_FFFF, 32'hF000_1234, 1'b0};
    vt[1] = '{2'b01, 32'hAAAA_AAAA, 32'h5555_5555, 32'hFFFF_FFFF, 1'b0};
    vt[2] = '{2'b10, 32'hAAAA_AAAA, 32'h5555_5555, 32'hFFFF_FFFF, 1'b0};
    vt[3] = '{2'b11, 32'hAAAA_AAAA, 32'h5555_5555, 32'h0000_0000, 1'b1};
    vt[4] = '{2'b00, 32'hFFFF_0000, 32'h0000_FFFF, 32'h0000_0000, 1'b1};
    vt[5] = '{2'b01, 32'h0000_0000, 32'h8000_0000, 32'h8000_0000, 1'b0};
    vt[6] = '{2'b11, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0};
    vt[7] = '{2'b10, 32'h1234_5678, 32'h1234_5678, 32'h0000_0000, 1'b1};
    vt[8] = '{2'b00, 32'h0000_0001, 32'h0000_0001, 32'h0000_0001, 1'b0};

    reset = 1'b1;
    #12;
    chk("rst_result", res0, 32'h0);
    chk("rst_iszero", {31'h0, z0}, 32'h0);
    chk("rst_rdy", {31'h0, rdy0}, 32'h0);
    chk("rst_busy", {31'h0, bsy0}, 32'h0);
    #11;
    reset = 1'b0;

    // Table: default config (4 cycles) and single-slice config (1 cycle).
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 9; i++) begin
        do_op(k, vt[i].op, vt[i].a, vt[i].b, lat, bc, r, z, rdy_nx, r_nx);
        chk($sformatf("lat_d%0d_v%0d", k, i), lat, (k == 0) ? 4 : 1);
        chk($sformatf("busy_d%0d_v%0d", k, i), bc, (k == 0) ? 4 : 1);
        chk($sformatf("res_d%0d_v%0d", k, i), r, vt[i].res);
        chk($sformatf("z_d%0d_v%0d", k, i), {31'h0, z}, {31'h0, vt[i].z});
        chk($sformatf("pulse_d%0d_v%0d", k, i), {31'h0, rdy_nx}, 32'h0);
        chk($sformatf("hold_d%0d_v%0d", k, i), r_nx, vt[i].res);
      end
    end

    // 16/4 config with random operands against the reference model.
    for (int i = 0; i < 8; i++) begin
      logic [1:0] op;
      logic [31:0] a, b;
      op = 2'($urandom_range(0, 3));
      a = {16'h0, 16'($urandom())};
      b = {16'h0, 16'($urandom())};
      if (i == 0) begin
        op = 2'b00; a = 32'h0000_00F0; b = 32'h0000_0F0F;
      end
      e = ref_f(op, a, b) & 32'h0000_FFFF;
      do_op(2, op, a, b, lat, bc, r, z, rdy_nx, r_nx);
      chk($sformatf("lat_d2_r%0d", i), lat, 4);
      chk($sformatf("res_d2_r%0d", i), r, e);
      chk($sformatf("z_d2_r%0d", i), {31'h0, z}, {31'h0, e == 0});
      chk($sformatf("pulse_d2_r%0d", i), {31'h0, rdy_nx}, 32'h0);
    end

    // Back-to-back: start held high through DONE.
    @(negedge clock);
    st[0] = 1'b1; opi[0] = 2'b00;
    ai[0] = 32'hFFFF_FFFF; bi[0] = 32'h0F0F_0F0F;
    @(posedge clock);
    #1;
    opi[0] = 2'b10; ai[0] = 32'h1234_5678; bi[0] = 32'h1234_5678;
    lat = 0;
    while (!rdy0 && lat < 20) begin
      @(posedge clock);
      #1;
      lat++;
    end
    chk("b2b_lat1", lat, 4);
    chk("b2b_res1", res0, 32'h0F0F_0F0F);
    cnt = 0;
    do begin
      @(posedge clock);
      #1;
      cnt++;
    end while (!rdy0 && cnt < 20);
    st[0] = 1'b0;
    chk("b2b_gap", cnt, 5);
    chk("b2b_res2", res0, 32'h0);
    chk("b2b_z2", {31'h0, z0}, 32'h1);
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clock);
      #1;
      if (rdy0) cnt++;
    end
    chk("b2b_no_third", cnt, 0);

    // Start during RUN is ignored.
    @(negedge clock);
    st[0] = 1'b1; opi[0] = 2'b00;
    ai[0] = 32'hF0F0_1234; bi[0] = 32'hFF00_FFFF;
    @(posedge clock);
    #1;
    st[0] = 1'b0;
    @(posedge clock);
    #1;
    st[0] = 1'b1; opi[0] = 2'b01;
    ai[0] = 32'hFFFF_FFFF; bi[0] = 32'hFFFF_FFFF;
    @(posedge clock);
    #1;
    st[0] = 1'b0;
    lat = 2;
    while (!rdy0 && lat < 20) begin
      @(posedge clock);
      #1;
      lat++;
    end
    chk("ign_lat", lat, 4);
    chk("ign_res", res0, 32'hF000_1234);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clock);
      #1;
      if (rdy0) cnt++;
    end
    chk("ign_no_extra", cnt, 0);
    chk("ign_hold", res0, 32'hF000_1234);

    // Async reset mid-RUN, between edges.
    @(negedge clock);
    st[0] = 1'b1; opi[0] = 2'b01;
    ai[0] = 32'hFFFF_FFFF; bi[0] = 32'h0;
    @(posedge clock);
    #1;
    st[0] = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #1;
    chk("pre_rst_partial", res0, 32'h0000_FFFF);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_result", res0, 32'h0);
    chk("arst_busy", {31'h0, bsy0}, 32'h0);
    chk("arst_rdy", {31'h0, rdy0}, 32'h0);
    #3;
    reset = 1'b0;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clock);
      #1;
      if (rdy0 || bsy0) cnt++;
    end
    chk("arst_quiet", cnt, 0);
    do_op(0, 2'b11, 32'h0F0F_0000, 32'h00F0_00FF,
          lat, bc, r, z, rdy_nx, r_nx);
    chk("post_rst_lat", lat, 4);
    chk("post_rst_res", r, 32'hF000_FF00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
